// File: rtl/lcd_arb_pkg.sv
// Shared definitions for the LCD access arbiter.
//   - Default values for the requester count, display word width and
//     acceptance timeout.
//   - State encoding of the arbiter FSM.
//   - ptr_width(): width of a requester index, never less than one bit.
package lcd_arb_pkg;

    localparam int LCD_NREQ_DEF        = 4;
    localparam int LCD_DATA_W_DEF      = 16;
    localparam int LCD_ACC_TIMEOUT_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_ACCEPT = 2'd1,
        ST_WAIT_DONE   = 2'd2,
        ST_DONE        = 2'd3
    } arb_state_e;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin winner selection (purely combinational).
// Searches the request vector starting at rr_ptr and moving upward with
// wrap-around. The first requester found wins.
// Ports:
//   req        in  NREQ   request vector
//   rr_ptr     in  PTR_W  index the search starts from
//   grant_next out NREQ   one-hot winner, zero when req is zero
module rr_priority_pick
    import lcd_arb_pkg::*;
#(
    parameter int NREQ  = LCD_NREQ_DEF,
    parameter int PTR_W = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  grant_next
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant_next = '0;
        found      = 1'b0;
        idx        = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                grant_next[idx] = 1'b1;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_arbiter.sv
// Arbiter that shares one LCD driver among NREQ requesters.
//
// When the arbiter is idle, it picks a requester in round-robin order. It
// latches that requester's display word and pulses lcd_start. It then waits
// for the driver to accept the transfer (lcd_busy rising) and to finish it
// (lcd_busy falling). Finally it acks the requester for one cycle. If the
// driver never raises lcd_busy within ACC_TIMEOUT cycles, the transfer ends
// with ack and err pulsed together.
//
// All outputs come straight from flops.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   req          in   NREQ         level requests, held until ack
//   req_data     in   NREQ*DATA_W  word per requester, slice i = [i*DATA_W +: DATA_W]
//   grant        out  NREQ         one-hot requester being served, 0 when idle
//   ack          out  NREQ         one-cycle completion pulse
//   err          out               one-cycle timeout flag, coincident with ack
//   lcd_start    out               one-cycle start pulse to the LCD driver
//   lcd_data_in  out  DATA_W       latched word for the LCD driver
//   lcd_busy     in                busy flag from the LCD driver
//   arb_busy     out               high whenever the FSM is not idle
module lcd_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int NREQ        = LCD_NREQ_DEF,
    parameter int DATA_W      = LCD_DATA_W_DEF,
    parameter int ACC_TIMEOUT = LCD_ACC_TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          grant,
    output logic [NREQ-1:0]          ack,
    output logic                     err,
    output logic                     lcd_start,
    output logic [DATA_W-1:0]        lcd_data_in,
    input  logic                     lcd_busy,
    output logic                     arb_busy
);

    localparam int PTR_W = ptr_width(NREQ);
    localparam int CNT_W = $clog2(ACC_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

    arb_state_e          state_q;
    logic [PTR_W-1:0]    rr_ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [PTR_W-1:0]    idx_q;
    logic [NREQ-1:0]     grant_q;
    logic [NREQ-1:0]     ack_q;
    logic                err_q;
    logic                start_q;
    logic [DATA_W-1:0]   data_q;
    logic                busy_q;

    logic [NREQ-1:0]     grant_next_d;
    logic [PTR_W-1:0]    win_idx_d;
    logic [DATA_W-1:0]   win_data_d;
    logic [PTR_W-1:0]    ptr_next_d;

    rr_priority_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .grant_next (grant_next_d)
    );

    // Index of the one-hot winner. It is needed to select the data slice and
    // to advance the round-robin pointer.
    always_comb begin
        win_idx_d = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_next_d[k]) begin
                win_idx_d = PTR_W'(k);
            end
        end
    end

    assign win_data_d = req_data[int'(win_idx_d)*DATA_W +: DATA_W];
    assign ptr_next_d = (idx_q == PTR_LAST) ? '0 : idx_q + 1'b1;

    // Pulse outputs (lcd_start, ack, err) default low every edge, so each
    // one lasts exactly one cycle. grant stays set through DONE so that it
    // lines up with ack, and it drops as the FSM returns to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            grant_q  <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            data_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        grant_q <= grant_next_d;
                        idx_q   <= win_idx_d;
                        data_q  <= win_data_d;
                        start_q <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT_ACCEPT;
                    end
                end
                ST_WAIT_ACCEPT: begin
                    // Acceptance takes priority, even on the last counted cycle.
                    if (lcd_busy) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        ack_q   <= grant_q;
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!lcd_busy) begin
                        ack_q   <= grant_q;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    grant_q  <= '0;
                    rr_ptr_q <= ptr_next_d;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign ack         = ack_q;
    assign err         = err_q;
    assign lcd_start   = start_q;
    assign lcd_data_in = data_q;
    assign arb_busy    = busy_q;

endmodule

// File: tb/tb_lcd_arbiter.sv
// Scoreboard bench for lcd_arbiter.
// Stimulus issues batches of simultaneous requests. For every transfer it
// pushes the expected start (grant, word) and the expected completion
// (ack, err, word, latency from start). It also pushes the LCD driver
// behaviour that decides err and latency. A monitor pops and compares these
// whenever the DUT pulses lcd_start or ack/err.
module tb_lcd_arbiter;

    localparam int NREQ   = 4;
    localparam int DATA_W = 16;
    localparam int T      = 8;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ*DATA_W-1:0] req_data = '0;
    logic                   lcd_busy = 1'b0;
    logic [NREQ-1:0]        grant;
    logic [NREQ-1:0]        ack;
    logic                   err;
    logic                   lcd_start;
    logic [DATA_W-1:0]      lcd_data_in;
    logic                   arb_busy;

    lcd_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ACC_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .ack(ack), .err(err), .lcd_start(lcd_start),
        .lcd_data_in(lcd_data_in), .lcd_busy(lcd_busy), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    // kind: 0 = accept after d cycles, hold busy l cycles
    //       1 = never accept (timeout)
    //       2 = busy already high before the start, hold l cycles
    typedef struct { int kind; int d; int l; } mode_t;
    typedef struct { logic [NREQ-1:0] grant; logic [DATA_W-1:0] data; } start_exp_t;
    typedef struct { logic [NREQ-1:0] ack; logic err; logic [DATA_W-1:0] data; int lat; } ack_exp_t;

    mode_t      modeq[$];
    start_exp_t startq[$];
    ack_exp_t   ackq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_ptr = 0;
    bit pre_cmd = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // LCD driver model
    initial begin : lcd_model
        int    phase;
        int    cnt;
        mode_t m;
        phase = 0;
        cnt = 0;
        m = '{0, 0, 1};
        forever begin
            @(negedge clk);
            if (reset) begin
                phase = 0;
                lcd_busy = 1'b0;
            end else if (lcd_start) begin
                if (modeq.size() != 0) begin
                    m = modeq.pop_front();
                    case (m.kind)
                        0: begin
                            if (m.d == 0) begin
                                lcd_busy = 1'b1; phase = 2; cnt = m.l;
                            end else begin
                                phase = 1; cnt = m.d;
                            end
                        end
                        1: phase = 0;
                        default: begin phase = 2; cnt = m.l; end
                    endcase
                end
            end else begin
                case (phase)
                    0: if (pre_cmd) begin lcd_busy = 1'b1; phase = 3; end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin lcd_busy = 1'b1; phase = 2; cnt = m.l; end
                    end
                    2: begin
                        cnt--;
                        if (cnt == 0) begin lcd_busy = 1'b0; phase = 0; end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Monitor / scoreboard
    initial begin : monitor
        start_exp_t s;
        ack_exp_t   a;
        bit         have_start;
        int         last_start;
        have_start = 1'b0;
        last_start = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                have_start = 1'b0;
            end else begin
                if (lcd_start) begin
                    if (startq.size() == 0) begin
                        chk("unexpected_start", 64'(lcd_start), 64'd0);
                    end else begin
                        s = startq.pop_front();
                        chk("start_grant", 64'(grant), 64'(s.grant));
                        chk("start_data", 64'(lcd_data_in), 64'(s.data));
                    end
                    if (have_start) chk("start_spacing_ge4", 64'((cyc - last_start) >= 4), 64'd1);
                    chk("start_arb_busy", 64'(arb_busy), 64'd1);
                    have_start = 1'b1;
                    last_start = cyc;
                end
                if (ack != '0 || err) begin
                    if (ackq.size() == 0) begin
                        chk("unexpected_ack", {59'd0, ack, err}, 64'd0);
                    end else begin
                        a = ackq.pop_front();
                        chk("ack_vec", 64'(ack), 64'(a.ack));
                        chk("ack_err", 64'(err), 64'(a.err));
                        chk("ack_data_held", 64'(lcd_data_in), 64'(a.data));
                        chk("ack_latency", 64'(cyc - last_start), 64'(a.lat));
                        chk("ack_arb_busy", 64'(arb_busy), 64'd1);
                    end
                end
            end
        end
    end

    task automatic run_batch(input logic [NREQ-1:0] mask, input logic [NREQ*DATA_W-1:0] dat,
                             input int fkind, input int fd, input int fl, input int mut);
        logic [NREQ-1:0] pending;
        logic [NREQ-1:0] oh;
        mode_t      m;
        start_exp_t s;
        ack_exp_t   a;
        int idx;
        int last;
        last = model_ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = (model_ptr + k) % NREQ;
            if (mask[idx]) begin
                if (fkind >= 0) begin
                    m.kind = fkind; m.d = fd; m.l = fl;
                end else begin
                    m.kind = ($urandom_range(0, 4) == 0) ? 1 : 0;
                    m.d = $urandom_range(0, T - 1);
                    m.l = $urandom_range(1, 12);
                end
                oh = '0;
                oh[idx] = 1'b1;
                s.grant = oh;
                s.data = dat[idx*DATA_W +: DATA_W];
                a.ack = oh;
                a.err = (m.kind == 1);
                a.data = s.data;
                a.lat = (m.kind == 0) ? m.d + m.l + 1 : (m.kind == 1) ? T : m.l + 1;
                modeq.push_back(m);
                startq.push_back(s);
                ackq.push_back(a);
                last = idx;
            end
        end
        model_ptr = (last + 1) % NREQ;
        if (fkind == 2) begin
            pre_cmd = 1'b1;
            repeat (2) @(negedge clk);
            pre_cmd = 1'b0;
        end
        @(negedge clk);
        req_data = dat;
        req = mask;
        pending = mask;
        for (int c = 0; c < 800 && pending != '0; c++) begin
            @(negedge clk);
            pending = pending & ~ack;
            req = req & ~ack;
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i] && req[i] && $urandom_range(0, 99) < mut) begin
                    req_data[i*DATA_W +: DATA_W] = dat[i*DATA_W +: DATA_W] ^ 16'h55FF;
                    req[i] = 1'b0;
                end
            end
        end
        if (pending != '0) chk("batch_complete", 64'(pending), 64'd0);
        req = '0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic reset_mid_transfer();
        mode_t      m;
        start_exp_t s;
        ack_exp_t   a;
        int         c;
        m = '{0, 1, 40};
        s.grant = 4'b0100;
        s.data = 16'hBEEF;
        a.ack = 4'b0100; a.err = 1'b0; a.data = 16'hBEEF; a.lat = 42;
        modeq.push_back(m);
        startq.push_back(s);
        ackq.push_back(a);
        @(negedge clk);
        req_data = {16'h0, 16'hBEEF, 16'h0, 16'h0};
        req = 4'b0100;
        c = 0;
        while (!lcd_busy && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("rst_reached_wait_done", 64'(lcd_busy), 64'd1);
        repeat (3) @(negedge clk);
        chk("pre_rst_grant", 64'(grant), 64'h4);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_grant", 64'(grant), 64'd0);
        chk("mid_rst_start", 64'(lcd_start), 64'd0);
        chk("mid_rst_ack", 64'(ack), 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        chk("mid_rst_data", 64'(lcd_data_in), 64'd0);
        chk("mid_rst_arb_busy", 64'(arb_busy), 64'd0);
        ackq.delete();
        modeq.delete();
        startq.delete();
        req = '0;
        model_ptr = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [NREQ-1:0] mask;
        #1 reset = 1'b1;
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_start", 64'(lcd_start), 64'd0);
        chk("rst_data", 64'(lcd_data_in), 64'd0);
        chk("rst_arb_busy", 64'(arb_busy), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // round robin from pointer 0, twice to show wrap-around
        run_batch(4'b1111, {$urandom, $urandom}, -1, 0, 0, 0);
        run_batch(4'b1111, {$urandom, $urandom}, -1, 0, 0, 0);
        // single normal transfer
        run_batch(4'b0001, {48'h0, 16'h1234}, 0, 2, 10, 0);
        // acceptance timeout
        run_batch(4'b0100, {$urandom, $urandom}, 1, 0, 0, 0);
        // request dropped and data changed while served
        run_batch(4'b0010, {32'h0, 16'h00AA, 16'h0}, 0, 1, 6, 100);
        // busy already high while idle
        run_batch(4'b1000, {$urandom, $urandom}, 2, 0, 4, 0);
        // acceptance on the very last counted cycle
        run_batch(4'b0001, {$urandom, $urandom}, 0, T - 1, 3, 0);
        // back-to-back minimum-length transfers
        run_batch(4'b1111, {$urandom, $urandom}, 0, 0, 1, 0);

        for (int n = 0; n < 40; n++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            run_batch(mask, {$urandom, $urandom}, -1, 0, 0, 20);
        end

        // move the pointer off zero, then reset in the middle of a transfer
        run_batch(4'b0001, {$urandom, $urandom}, 0, 0, 2, 0);
        reset_mid_transfer();
        run_batch(4'b1111, {$urandom, $urandom}, -1, 0, 0, 0);

        repeat (5) @(negedge clk);
        chk("end_grant", 64'(grant), 64'd0);
        chk("end_arb_busy", 64'(arb_busy), 64'd0);
        chk("end_queues_empty", 64'(startq.size() + ackq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_arbiter.md
LCD_ARBITER -- requirements
Module: lcd_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- NREQ, default 4: number of requesters.
- DATA_W, default 16: width of the display word.
- ACC_TIMEOUT, default 8: number of cycles to wait for lcd_busy to rise after a start.

REQ-002 The block SHALL have these ports:
- clk  in  1: single clock; all state updates on the rising edge.
- reset  in  1: asynchronous, active-high reset.
- req  in  NREQ: level request per requester, held until the matching ack.
- req_data  in  NREQ*DATA_W: display word per requester; slice i is [i*DATA_W +: DATA_W].
- grant  out  NREQ: one-hot marker of the requester being served; zero when idle.
- ack  out  NREQ: one-cycle pulse to the served requester when its transfer finishes.
- err  out  1: one-cycle pulse, coincident with ack, when the transfer timed out.
- lcd_start  out  1: one-cycle start pulse to the LCD driver.
- lcd_data_in  out  DATA_W: word presented to the LCD driver.
- lcd_busy  in  1: busy flag from the LCD driver.
- arb_busy  out  1: high whenever the state is not IDLE.

Function
REQ-003 The state machine SHALL have the states IDLE, WAIT_ACCEPT, WAIT_DONE and DONE; every output SHALL be registered.
REQ-004 In IDLE with req != 0, the next edge SHALL perform all of the following:
- select the winner i using round-robin, searching from rr_ptr upward with wrap-around;
- set grant to one-hot bit i;
- latch lcd_data_in from slice i of req_data;
- set lcd_start to 1, clear the timeout counter, and enter WAIT_ACCEPT.
REQ-005 lcd_start SHALL be high for exactly one cycle per transfer; the edge after it is asserted SHALL clear it, regardless of state.
REQ-006 WAIT_ACCEPT SHALL behave as follows:
- lcd_busy == 1 moves the state to WAIT_DONE.
- Otherwise the counter increments each cycle.
- When the counter reaches ACC_TIMEOUT-1 with lcd_busy still 0, the state moves to DONE with the timeout flag set.
REQ-007 WAIT_DONE SHALL wait for lcd_busy == 0 and then move to DONE; it SHALL have no timeout.
REQ-008 DONE SHALL last one cycle and SHALL:
- pulse ack[i], plus err if the timeout flag is set;
- clear grant;
- set rr_ptr to (i+1) mod NREQ;
- return to IDLE.
REQ-009 A new grant SHALL NOT be issued in the cycle of DONE; the minimum spacing between start pulses SHALL be 4 cycles.
REQ-010 Changes to req_data after the latch point SHALL NOT affect lcd_data_in for the current transfer.
REQ-011 If req[i] is dropped while requester i holds the grant, the transfer SHALL still complete and ack[i] SHALL still pulse.
REQ-012 Simultaneous requests SHALL be served in round-robin order; a requester holding req continuously SHALL be served within NREQ transfers (no starvation).
REQ-013 If lcd_busy is already high in IDLE, the arbiter SHALL still grant; acceptance is then seen immediately in WAIT_ACCEPT.

Reset
REQ-014 While reset is high, all of the following SHALL hold immediately, without waiting for a clock edge:
- state = IDLE, rr_ptr = 0, counter = 0;
- grant = 0, ack = 0, err = 0, lcd_start = 0;
- lcd_data_in = 0, arb_busy = 0.
REQ-015 A reset during any transfer SHALL abandon it with no ack; after release, the first grant SHALL follow REQ-004 with rr_ptr = 0.

Structure
REQ-016 The state encoding, the NREQ and DATA_W defaults, and the ACC_TIMEOUT default SHALL live in a shared package, lcd_arb_pkg.
REQ-017 Winner selection SHALL be a combinational sub-module, rr_priority_pick, with inputs (req, rr_ptr) and output one-hot grant_next.

Verification
REQ-018 Single request, normal transfer:
- Stimulus: req=0001, data0=0x1234; lcd_busy rises 2 cycles after start and falls 10 cycles later.
- Response: one lcd_start pulse, lcd_data_in=0x1234, ack=0001 once, err=0.
REQ-019 Round-robin order:
- Stimulus: req=1111 held, rr_ptr=0.
- Response: grants in the order 0001, 0010, 0100, 1000, 0001; rr_ptr wraps 3 -> 0.
REQ-020 Acceptance timeout:
- Stimulus: req=0100; lcd_busy held 0.
- Response: ack=0100 and err=1 in the same cycle; DONE is reached ACC_TIMEOUT cycles after WAIT_ACCEPT is entered.
REQ-021 Request dropped and data changed mid-transfer:
- Stimulus: req[1] dropped and data1 changed from 0x00AA to 0x5555 during WAIT_DONE.
- Response: lcd_data_in stays 0x00AA; ack[1] still pulses.
REQ-022 Reset mid-transfer:
- Stimulus: reset asserted in WAIT_DONE.
- Response: grant, lcd_start and ack go to 0 without a clock edge; no ack follows; after release the next grant starts search from requester 0.
